// File: rtl/serial_pkg.sv
// Shared definitions for the serial path: serializer FSM states and default
// word/FIFO sizes, also imported by the pattern detector.
package serial_pkg;

   localparam int SER_WIDTH = 8;
   localparam int SER_DEPTH = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

endpackage

// File: rtl/ser_fifo.sv
// Small synchronous FIFO holding parallel words ahead of the serializer.
// The head word is visible on dout whenever the FIFO is non-empty.
module ser_fifo
   import serial_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH,
   parameter int DEPTH = SER_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: queues words in ser_fifo and shifts them out
// one bit per clock, back to back when the next word is already queued.
module bit_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH     = SER_WIDTH,
   parameter int DEPTH     = SER_DEPTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             out,
   output logic             out_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic             frame_start_q, frame_start_d;
   logic             busy_q, busy_d;
   logic             din_ready_q, din_ready_d;

   logic             push, pop;
   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_full, fifo_empty;
   logic [CW-1:0]    fifo_count, next_count;

   assign push = din_valid && din_ready_q && !fifo_full;

   ser_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Outputs are derived from the next-state values so every port is a flop.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_d = fifo_dout;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == LAST_BIT) begin
               cnt_d = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shreg_d = fifo_dout;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      next_count = fifo_count;
      if (push && !pop)      next_count = fifo_count + CW'(1);
      else if (!push && pop) next_count = fifo_count - CW'(1);

      out_valid_d   = (state_d == SHIFT);
      out_d         = out_valid_d && (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
      frame_start_d = out_valid_d && (cnt_d == '0);
      busy_d        = out_valid_d || (next_count != '0);
      din_ready_d   = (next_count < CW'(DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         shreg_q       <= '0;
         cnt_q         <= '0;
         out_q         <= 1'b0;
         out_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
         din_ready_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         cnt_q         <= cnt_d;
         out_q         <= out_d;
         out_valid_q   <= out_valid_d;
         frame_start_q <= frame_start_d;
         busy_q        <= busy_d;
         din_ready_q   <= din_ready_d;
      end
   end

   assign out         = out_q;
   assign out_valid   = out_valid_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_q;
   assign din_ready   = din_ready_q;

endmodule
